// File: rtl/shot_ctrl.sv
// shot_ctrl: spawns, moves and retires up to MAX_SHOTS player projectiles.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clk_en         : one-clk game tick strobe
//   swF            : fire switch, active-low
//   scene          : current scene code; shots live only in PLAY_SCENE
//   player_pos     : player X, copied into a new shot
//   hit_valid/idx  : collision report, kills slot hit_idx
//   shot_valid     : per-slot live flag
//   shot_x/shot_y  : packed per-slot coordinates (9 / 8 bits per slot)
//   fire_event     : one-clk pulse on each spawn
module shot_ctrl #(
    parameter int         MAX_SHOTS  = 4,
    parameter int         COOLDOWN   = 15,
    parameter logic [7:0] Y_START    = 8'd200,
    parameter logic [7:0] Y_MIN      = 8'd16,
    parameter logic [7:0] SPEED      = 8'd2,
    parameter logic [1:0] PLAY_SCENE = 2'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   swF,
    input  logic [1:0]             scene,
    input  logic [8:0]             player_pos,
    input  logic                   hit_valid,
    input  logic [2:0]             hit_idx,
    output logic [MAX_SHOTS-1:0]   shot_valid,
    output logic [9*MAX_SHOTS-1:0] shot_x,
    output logic [8*MAX_SHOTS-1:0] shot_y,
    output logic                   fire_event
);

    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
    // A shot below this Y cannot take another full step without
    // leaving the playfield, so it is retired instead of moved.
    localparam logic [7:0] Y_RETIRE = Y_MIN + SPEED;

    logic [CW-1:0]          cooldown;
    logic [CW-1:0]          cooldown_n;
    logic [MAX_SHOTS-1:0]   valid_n;
    logic [MAX_SHOTS-1:0]   hit_mask;
    logic [9*MAX_SHOTS-1:0] x_n;
    logic [8*MAX_SHOTS-1:0] y_n;
    logic                   fire_n;
    logic                   has_free;
    logic [2:0]             free_idx;
    logic                   spawn;
    logic                   play;

    assign play = (scene == PLAY_SCENE);

    // Lowest-index free slot, judged on pre-edge state only.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
            if (!shot_valid[i]) begin
                has_free = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    // Out-of-range or dead-slot hits never match a bit here.
    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            hit_mask[i] = hit_valid && (hit_idx == 3'(i)) && shot_valid[i];
        end
    end

    assign spawn = play && clk_en && !swF && (cooldown == '0) && has_free;

    always_comb begin
        valid_n    = shot_valid;
        x_n        = shot_x;
        y_n        = shot_y;
        cooldown_n = cooldown;
        fire_n     = 1'b0;
        if (!play) begin
            valid_n    = '0;
            cooldown_n = '0;
        end else begin
            valid_n = shot_valid & ~hit_mask;
            if (clk_en) begin
                for (int i = 0; i < MAX_SHOTS; i++) begin
                    if (shot_valid[i] && !hit_mask[i]) begin
                        if (shot_y[8*i +: 8] < Y_RETIRE) begin
                            valid_n[i] = 1'b0;
                        end else begin
                            y_n[8*i +: 8] = shot_y[8*i +: 8] - SPEED;
                        end
                    end
                end
                if (cooldown != '0) begin
                    cooldown_n = cooldown - CW'(1);
                end
            end
            // The chosen slot was free pre-edge, so it never collides
            // with the hit/move updates above.
            for (int i = 0; i < MAX_SHOTS; i++) begin
                if (spawn && (free_idx == 3'(i))) begin
                    valid_n[i]    = 1'b1;
                    x_n[9*i +: 9] = player_pos;
                    y_n[8*i +: 8] = Y_START;
                end
            end
            if (spawn) begin
                cooldown_n = CD_LOAD;
                fire_n     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shot_valid <= '0;
            shot_x     <= '0;
            shot_y     <= '0;
            cooldown   <= '0;
            fire_event <= 1'b0;
        end else begin
            shot_valid <= valid_n;
            shot_x     <= x_n;
            shot_y     <= y_n;
            cooldown   <= cooldown_n;
            fire_event <= fire_n;
        end
    end

endmodule
